// File: rtl/arb2_4b.sv
// rtl/arb2_4b.sv - two-requester round-robin arbiter feeding a single-entry output buffer
module arb2_4b #(
    parameter int nbits = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in0_val,
    output logic             in0_rdy,
    input  logic [nbits-1:0] in0_data,
    input  logic             in1_val,
    output logic             in1_rdy,
    input  logic [nbits-1:0] in1_data,
    output logic             out_val,
    input  logic             out_rdy,
    output logic [nbits-1:0] out_data,
    output logic             sel,
    output logic             prio
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [nbits-1:0] buf_data;
    logic [nbits-1:0] buf_data_next;
    logic             prio_next;
    logic             grant1;
    logic             can_accept;
    logic             xfer_in;
    logic             xfer_out;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= EMPTY;
            buf_data <= '0;
            prio     <= 1'b0;
        end else begin
            state    <= state_next;
            buf_data <= buf_data_next;
            prio     <= prio_next;
        end
    end

    always_comb begin
        state_next    = state;
        buf_data_next = buf_data;
        prio_next     = prio;

        // Requester 1 wins when alone, or when both ask and it holds priority.
        grant1     = in1_val & (~in0_val | prio);
        can_accept = (state == EMPTY) | out_rdy;

        sel     = grant1;
        // Ready is suppressed while reset is held so no handshake can complete.
        in0_rdy = reset & in0_val & ~grant1 & can_accept;
        in1_rdy = reset & grant1 & can_accept;

        xfer_in  = in0_rdy | in1_rdy;
        xfer_out = (state == FULL) & out_rdy;

        case (state)
            EMPTY:   if (xfer_in) state_next = FULL;
            FULL:    if (xfer_out && !xfer_in) state_next = EMPTY;
            default: state_next = EMPTY;
        endcase

        if (xfer_in) begin
            buf_data_next = grant1 ? in1_data : in0_data;
            prio_next     = ~grant1;
        end
    end

    assign out_val  = (state == FULL);
    assign out_data = buf_data;

endmodule

// File: tb/tb_arb2_4b.sv
// tb/tb_arb2_4b.sv - self-checking bench for arb2_4b with a behavioural reference model
module tb_arb2_4b;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       in0_val = 1'b0;
    logic       in0_rdy;
    logic [3:0] in0_data = 4'h0;
    logic       in1_val = 1'b0;
    logic       in1_rdy;
    logic [3:0] in1_data = 4'h0;
    logic       out_val;
    logic       out_rdy = 1'b0;
    logic [3:0] out_data;
    logic       sel;
    logic       prio;

    int errors = 0;
    int checks = 0;

    arb2_4b #(.nbits(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .in0_val  (in0_val),
        .in0_rdy  (in0_rdy),
        .in0_data (in0_data),
        .in1_val  (in1_val),
        .in1_rdy  (in1_rdy),
        .in1_data (in1_data),
        .out_val  (out_val),
        .out_rdy  (out_rdy),
        .out_data (out_data),
        .sel      (sel),
        .prio     (prio)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: buffer occupancy, last captured word, favoured requester.
    bit       m_full = 1'b0;
    bit [3:0] m_data = 4'h0;
    bit       m_prio = 1'b0;

    function automatic int m_winner();
        if (in0_val && in1_val) return int'(m_prio);
        if (in0_val) return 0;
        if (in1_val) return 1;
        return -1;
    endfunction

    function automatic bit m_ready(input int k);
        return reset && (m_winner() == k) && (!m_full || out_rdy);
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_full = 1'b0;
            m_data = 4'h0;
            m_prio = 1'b0;
        end else begin
            int w;
            w = m_winner();
            if (w >= 0 && m_ready(w)) begin
                m_data = (w == 1) ? in1_data : in0_data;
                m_full = 1'b1;
                m_prio = (w == 0);
            end else if (m_full && out_rdy) begin
                m_full = 1'b0;
            end
        end
    end

    bit compare_on = 1'b0;

    always @(negedge clk) begin
        if (compare_on) begin
            chk("mdl_in0_rdy", {3'b0, in0_rdy}, {3'b0, m_ready(0)});
            chk("mdl_in1_rdy", {3'b0, in1_rdy}, {3'b0, m_ready(1)});
            chk("mdl_sel", {3'b0, sel}, {3'b0, m_winner() == 1});
            chk("mdl_out_val", {3'b0, out_val}, {3'b0, m_full});
            chk("mdl_out_data", out_data, m_data);
            chk("mdl_prio", {3'b0, prio}, {3'b0, m_prio});
            chk("mdl_one_hot_rdy", {3'b0, in0_rdy & in1_rdy}, 4'h0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] rr_exp [4];
        logic       rr_sel [4];
        rr_exp = '{4'b0011, 4'b1100, 4'b0011, 4'b1100};
        rr_sel = '{1'b0, 1'b1, 1'b0, 1'b1};

        compare_on = 1'b1;

        // Reset held with both requesters valid.
        in0_val = 1'b1;
        in1_val = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("rst_out_val", {3'b0, out_val}, 4'h0);
            chk("rst_out_data", out_data, 4'b0000);
            chk("rst_prio", {3'b0, prio}, 4'h0);
            chk("rst_in0_rdy", {3'b0, in0_rdy}, 4'h0);
            chk("rst_in1_rdy", {3'b0, in1_rdy}, 4'h0);
        end

        reset    = 1'b1;
        out_rdy  = 1'b1;
        in0_data = 4'b0101;
        #1;
        chk("rel_in0_rdy", {3'b0, in0_rdy}, 4'h1);
        chk("rel_in1_rdy", {3'b0, in1_rdy}, 4'h0);
        chk("rel_sel", {3'b0, sel}, 4'h0);

        // Single requester 1.
        step();
        in0_val  = 1'b0;
        in1_val  = 1'b1;
        in1_data = 4'b1010;
        #1;
        chk("single_in1_rdy", {3'b0, in1_rdy}, 4'h1);
        chk("single_sel", {3'b0, sel}, 4'h1);
        step();
        in1_val = 1'b0;
        chk("single_out_val", {3'b0, out_val}, 4'h1);
        chk("single_out_data", out_data, 4'b1010);
        chk("single_prio", {3'b0, prio}, 4'h0);

        // Round-robin under continuous dual requests.
        in0_val  = 1'b1;
        in1_val  = 1'b1;
        in0_data = 4'b0011;
        in1_data = 4'b1100;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rr_sel", {3'b0, sel}, {3'b0, rr_sel[i]});
            step();
            chk("rr_out_data", out_data, rr_exp[i]);
        end

        // Backpressure with 0111 in the buffer.
        in1_val  = 1'b0;
        in0_data = 4'b0111;
        step();
        in1_val  = 1'b1;
        in0_data = 4'b0001;
        in1_data = 4'b0010;
        out_rdy  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_in0_rdy", {3'b0, in0_rdy}, 4'h0);
            chk("bp_in1_rdy", {3'b0, in1_rdy}, 4'h0);
            chk("bp_out_data", out_data, 4'b0111);
            chk("bp_prio", {3'b0, prio}, 4'h1);
            step();
        end
        out_rdy = 1'b1;
        #1;
        chk("bp_refill_in1_rdy", {3'b0, in1_rdy}, 4'h1);
        step();
        chk("bp_refill_out_val", {3'b0, out_val}, 4'h1);
        chk("bp_refill_out_data", out_data, 4'b0010);
        chk("bp_refill_prio", {3'b0, prio}, 4'h0);

        // Drain to empty.
        in1_val  = 1'b0;
        in0_data = 4'b1001;
        step();
        in0_val = 1'b0;
        chk("drain_full_data", out_data, 4'b1001);
        step();
        chk("drain_out_val", {3'b0, out_val}, 4'h0);
        chk("drain_stale_data", out_data, 4'b1001);
        in0_val = 1'b1;
        out_rdy = 1'b0;
        #1;
        chk("drain_in0_rdy", {3'b0, in0_rdy}, 4'h1);

        // Asynchronous reset while full.
        in0_data = 4'b1110;
        step();
        in0_val = 1'b0;
        chk("mid_full_data", out_data, 4'b1110);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_out_val", {3'b0, out_val}, 4'h0);
        chk("mid_rst_prio", {3'b0, prio}, 4'h0);
        step();
        reset    = 1'b1;
        out_rdy  = 1'b1;
        in0_val  = 1'b1;
        in1_val  = 1'b1;
        in0_data = 4'b0110;
        in1_data = 4'b1011;
        #1;
        chk("resume_in0_rdy", {3'b0, in0_rdy}, 4'h1);
        chk("resume_sel", {3'b0, sel}, 4'h0);
        step();
        chk("resume_out_data", out_data, 4'b0110);

        // Mixed directed pattern checked against the model only.
        for (int i = 0; i < 32; i++) begin
            in0_val  = i[0];
            in1_val  = i[1] | i[3];
            out_rdy  = ~i[2] | i[4];
            in0_data = 4'(i * 3);
            in1_data = 4'(15 - i);
            step();
        end

        compare_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
